legv8_regfile_param: RTL and testbench
======================================

# legv8_regfile_param

Parametrised LEGv8 general-purpose register file with two synchronous read ports and one write port. It adds a hardwired zero register (XZR), optional write-to-read bypass, and a hardware clear sequencer that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write port) in the LEGv8 datapath, replacing the fixed 64x32 register file.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers (derived, not overridable)
- ZERO_REG, 31, index that always reads 0 and ignores writes; must be < DEPTH
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the old value

Ports:
- clk  in  1  rising-edge clock (the single clock)
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  read enable; 0 holds both read outputs
- rd_addr_1  in  ADDR_W  read port 1 address
- rd_addr_2  in  ADDR_W  read port 2 address
- rd_data_1  out  DATA_W  registered read data, port 1
- rd_data_2  out  DATA_W  registered read data, port 2
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  single-cycle pulse; starts a full-array clear
- busy  out  1  1 while a clear sweep is in progress; all ports are ignored while it is high

## Operation
- FSM has two states, CLEAR and IDLE, plus a clear index clr_idx (ADDR_W bits).
- Asynchronous reset (rst_n=0):
  - state = CLEAR, clr_idx = 0, busy = 1
  - rd_data_1 = rd_data_2 = 0
  - array contents are not reset directly; the sweep zeroes them.
- CLEAR state:
  - each rising edge writes 0 to MEM[clr_idx] and increments clr_idx.
  - on the edge that clears DEPTH-1, the FSM goes to IDLE and busy falls.
- IDLE state: clr_req=1 moves to CLEAR with clr_idx=0. clr_req while in CLEAR is ignored; the sweep does not restart.
- Write:
  - accepted on a rising edge when wr_en=1, busy=0 and wr_addr != ZERO_REG.
  - writes while busy=1 are dropped silently.
  - writes to ZERO_REG are always discarded.
- Read:
  - on a rising edge with rd_en=1 and busy=0, rd_data_n loads MEM[rd_addr_n].
  - rd_en=0 holds the previous values.
  - while busy=1, both read outputs load 0 every edge.
- Zero register: a read of ZERO_REG returns 0 regardless of array contents or bypass.
- Bypass:
  - with BYPASS=1, an accepted write with wr_addr == rd_addr_n in the same cycle makes rd_data_n load wr_data.
  - with BYPASS=0 the read returns the pre-write value.
  - both ports may bypass at the same time.
- Both read ports may address the same register.
- A write is never blocked by a read.

## Timing
- Read latency: 1 cycle. Address presented before edge N, data valid after edge N.
- Write visibility:
  - the stored value is readable by a read issued on edge N+1.
  - with BYPASS=1, it is also readable by a read issued on edge N.
- Clear sweep: exactly DEPTH edges. busy is high for edges 1..DEPTH after reset release or after the clr_req edge, and low after edge DEPTH.
  - DEPTH=32 gives 32 cycles.
- Reset asserted mid-sweep: the sweep restarts at index 0.
- Reset asserted mid-operation: read outputs go to 0 immediately (asynchronously).
- No combinational path from any input to any output; busy and rd_data are registered.

## Test plan
- Reset release: hold rst_n low, then release. busy=1 for exactly 32 cycles. Then read every address -> all return 0.
- Write/read: write X5=0xDEAD_BEEF_0123_4567. Next cycle read rd_addr_1=5, rd_addr_2=5 -> both 0xDEAD_BEEF_0123_4567 one cycle later.
- XZR: write 0xFFFF_FFFF_FFFF_FFFF to X31, then read X31 -> 0, including the bypass case.
- Bypass: in one cycle, write X7=0x1234 and read X7.
  - BYPASS=1 -> 0x1234.
  - BYPASS=0 -> previous value 0.
- Clear during use: fill X0..X30 with nonzero values, pulse clr_req.
  - A write of X3=0x55 during busy is dropped.
  - After busy falls, every read returns 0.
- rd_en hold and mid-sweep reset:
  - rd_en=0 with changing addresses -> outputs hold.
  - Assert rst_n=0 at sweep index 10 -> busy stays high for 32 further cycles after release.

Source files
------------

// File: rtl/legv8_regfile_param.sv
// legv8_regfile_param: LEGv8 register file, 2 sync read ports, 1 write port, XZR, optional bypass, clear sweep.
module legv8_regfile_param #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] clr_idx, clr_idx_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic wr_ok;
    logic [DATA_W-1:0] rd_nx_1, rd_nx_2;
    assign busy  = state == CLEAR;
    assign wr_ok = wr_en && !busy && wr_addr != ZR;
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nx = clr_idx + 1'b1;
            state_nx   = &clr_idx ? IDLE : CLEAR;
        end else if (clr_req) begin
            state_nx   = CLEAR;
            clr_idx_nx = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end
    // XZR wins over bypass, bypass wins over the stored value
    assign rd_nx_1 = rd_addr_1 == ZR ? '0 :
                     (BYPASS != 0 && wr_ok && wr_addr == rd_addr_1) ? wr_data : mem[rd_addr_1];
    assign rd_nx_2 = rd_addr_2 == ZR ? '0 :
                     (BYPASS != 0 && wr_ok && wr_addr == rd_addr_2) ? wr_data : mem[rd_addr_2];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_1 <= '0;
            rd_data_2 <= '0;
        end else if (busy) begin
            rd_data_1 <= '0;
            rd_data_2 <= '0;
        end else if (rd_en) begin
            rd_data_1 <= rd_nx_1;
            rd_data_2 <= rd_nx_2;
        end
    end
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_idx] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_legv8_regfile_param.sv
// tb_legv8_regfile_param: directed vectors for the register file, with and without bypass.
module tb_legv8_regfile_param;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        rd_en = 0, wr_en = 0, clr_req = 0;
    logic [4:0]  rd_addr_1 = 0, rd_addr_2 = 0, wr_addr = 0;
    logic [63:0] wr_data = 0;
    logic [63:0] rd_data_1, rd_data_2, nb_rd_1, nb_rd_2;
    logic        busy, nb_busy;
    int total = 0, bad = 0, cnt;

    always #5 clk = ~clk;

    legv8_regfile_param #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr_req(clr_req), .busy(busy)
    );
    legv8_regfile_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(nb_rd_1), .rd_data_2(nb_rd_2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr_req(clr_req), .busy(nb_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        re;
        logic [4:0]  a1, a2;
        logic [63:0] e1, e2, enb;
    } vec_t;
    vec_t v[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_busy(input string name);
        cnt = 0;
        while (busy && cnt < 200) begin
            step();
            cnt++;
        end
        chk(name, 64'(cnt), 64'd32);
    endtask

    initial begin
        v[0]  = '{1, 5,  64'hDEAD_BEEF_0123_4567, 0, 0,  0,  64'h0,    64'h0,    64'h0};
        v[1]  = '{0, 0,  64'h0,                  1, 5,  5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        v[2]  = '{1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 31, 64'h0,    64'h0,    64'h0};
        v[3]  = '{0, 0,  64'h0,                  1, 31, 5,  64'h0,    64'hDEAD_BEEF_0123_4567, 64'h0};
        v[4]  = '{1, 7,  64'h1234,               1, 7,  7,  64'h1234, 64'h1234, 64'h0};
        v[5]  = '{0, 0,  64'h0,                  1, 7,  5,  64'h1234, 64'hDEAD_BEEF_0123_4567, 64'h1234};
        v[6]  = '{1, 1,  64'hAAAA,               0, 1,  2,  64'h1234, 64'hDEAD_BEEF_0123_4567, 64'h1234};
        v[7]  = '{1, 2,  64'hBBBB,               1, 1,  2,  64'hAAAA, 64'hBBBB, 64'hAAAA};
        v[8]  = '{1, 9,  64'h99,                 1, 9,  9,  64'h99,   64'h99,   64'h0};
        v[9]  = '{1, 4,  64'h44,                 1, 2,  4,  64'hBBBB, 64'h44,   64'hBBBB};
        v[10] = '{0, 0,  64'h0,                  0, 5,  5,  64'hBBBB, 64'h44,   64'hBBBB};
        v[11] = '{0, 0,  64'h0,                  1, 4,  9,  64'h44,   64'h99,   64'h44};

        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_rd1", rd_data_1, 64'h0);
        chk("reset_rd2", rd_data_2, 64'h0);
        rst_n = 1;
        count_busy("release_busy_cycles");
        chk("nb_busy_low", 64'(nb_busy), 64'd0);

        rd_en = 1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_1 = 5'(i);
            rd_addr_2 = 5'(31 - i);
            step();
            chk("init_zero_rd1", rd_data_1, 64'h0);
            chk("init_zero_rd2", rd_data_2, 64'h0);
        end

        for (int i = 0; i < 12; i++) begin
            wr_en = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd;
            rd_en = v[i].re; rd_addr_1 = v[i].a1; rd_addr_2 = v[i].a2;
            step();
            chk($sformatf("vec%0d_rd1", i), rd_data_1, v[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd_data_2, v[i].e2);
            chk($sformatf("vec%0d_nb_rd1", i), nb_rd_1, v[i].enb);
        end

        rd_en = 0;
        for (int i = 0; i < 31; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 64'hA000 | 64'(i + 1);
            step();
        end
        wr_en = 0; rd_en = 1; rd_addr_1 = 30; rd_addr_2 = 0;
        step();
        chk("fill_x30", rd_data_1, 64'hA01F);
        chk("fill_x0", rd_data_2, 64'hA001);

        rd_en = 0; clr_req = 1;
        step();
        clr_req = 0;
        chk("clr_busy", 64'(busy), 64'd1);
        cnt = 0;
        while (busy && cnt < 200) begin
            wr_en = (cnt == 0); wr_addr = 3; wr_data = 64'h55;
            clr_req = (cnt == 5); rd_en = 1; rd_addr_1 = 3; rd_addr_2 = 30;
            step();
            cnt++;
            if (cnt == 1) chk("busy_read_zero", rd_data_2, 64'h0);
        end
        wr_en = 0; clr_req = 0;
        chk("clr_busy_cycles", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i++) begin
            rd_addr_1 = 5'(i);
            rd_addr_2 = 5'((i + 3) % 32);
            step();
            chk("cleared_rd1", rd_data_1, 64'h0);
            chk("cleared_rd2", rd_data_2, 64'h0);
        end

        wr_en = 1; wr_addr = 8; wr_data = 64'h88; rd_addr_1 = 8; rd_addr_2 = 8;
        step();
        wr_en = 0;
        chk("pre_reset_rd1", rd_data_1, 64'h88);
        #2 rst_n = 0;
        #1;
        chk("async_rst_rd1", rd_data_1, 64'h0);
        chk("async_rst_rd2", rd_data_2, 64'h0);
        chk("async_rst_busy", 64'(busy), 64'd1);
        step();
        rst_n = 1;
        count_busy("rst_release_busy_cycles");
        rd_addr_1 = 8;
        step();
        chk("after_reset_x8", rd_data_1, 64'h0);

        clr_req = 1;
        step();
        clr_req = 0;
        repeat (10) step();
        chk("midsweep_busy", 64'(busy), 64'd1);
        rst_n = 0;
        step();
        rst_n = 1;
        count_busy("midsweep_restart_cycles");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
